// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the PC fetch stage: FSM encoding, default reset PC,
// sequential increment and the redirect alignment mask.
package pc_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_INC      = 4;
    localparam logic [1:0]  ALIGN_MASK   = 2'b11;

endpackage

// File: rtl/two_way_mux.sv
// 1-bit datapath mux cell: y = s ? d1 : d0.
module two_way_mux (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/pc_fetch_stage.sv
// Program-counter register stage: picks sequential or redirect PC through a row of
// 1-bit mux cells and offers it to fetch over valid/ready; halts on misaligned redirect.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int               INC      = DEF_INC,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready_i,
    input  logic             br_taken_i,
    input  logic [XLEN-1:0]  br_target_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_valid_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, seq_pc, pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             misalign_q;
    logic             in_run, fire, tgt_misaligned, redirect_ok, redirect_bad;

    assign in_run         = (state_q == ST_RUN);
    assign fire           = in_run & fetch_ready_i;
    assign tgt_misaligned = |(br_target_i[1:0] & ALIGN_MASK);
    assign redirect_ok    = in_run & br_taken_i & ~tgt_misaligned;
    assign redirect_bad   = in_run & br_taken_i &  tgt_misaligned;

    // A misaligned redirect freezes pc_o even if the current PC was accepted.
    assign seq_pc = (fire & ~redirect_bad) ? pc_q + XLEN'(INC) : pc_q;

    for (genvar i = 0; i < XLEN; i++) begin : g_pc_mux
        two_way_mux u_mux (
            .d0 (seq_pc[i]),
            .d1 (br_target_i[i]),
            .s  (redirect_ok),
            .y  (pc_d[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (redirect_bad) state_d = ST_HALT;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fire)         cnt_q      <= cnt_q + CNT_W'(1);
            if (redirect_bad) misalign_q <= 1'b1;
        end
    end

    assign pc_o          = pc_q;
    assign pc_valid_o    = in_run;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed vector table, then random traffic against a
// behavioural model of the fetch stage.
module tb_pc_fetch_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fetch_ready_i;
    logic             br_taken_i;
    logic [XLEN-1:0]  br_target_i;
    logic [XLEN-1:0]  pc_o;
    logic             pc_valid_o;
    logic             misalign_o;
    logic [CNT_W-1:0] fetch_count_o;

    int errors = 0;
    int checks = 0;

    pc_fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0), .INC(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_ready_i (fetch_ready_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        int          cnt;
    } vec_t;

    // Reference model: phase 0 = waiting one cycle after reset, 1 = running, 2 = halted.
    int          m_phase;
    logic [31:0] m_pc;
    int          m_cnt;
    logic        m_mis;

    task automatic model_edge(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
        if (r) begin
            m_phase = 0; m_pc = 32'h0; m_cnt = 0; m_mis = 1'b0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (rdy) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (br && (tgt % 4 != 0)) begin
                m_phase = 2; m_mis = 1'b1;
            end else if (br) begin
                m_pc = tgt;
            end else if (rdy) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
        rst = r; fetch_ready_i = rdy; br_taken_i = br; br_target_i = tgt;
        @(posedge clk);
        #1;
        model_edge(r, rdy, br, tgt);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    pc_o,                   m_pc);
        check({tag, ".valid"}, {31'd0, pc_valid_o},    {31'd0, m_phase == 1});
        check({tag, ".mis"},   {31'd0, misalign_o},    {31'd0, m_mis});
        check({tag, ".cnt"},   {28'd0, fetch_count_o}, 32'(m_cnt));
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rdy, logic br, logic [31:0] tgt,
                                logic [31:0] pc, logic v, logic mis, int cnt);
        vec_t t;
        t.rst = r; t.ready = rdy; t.br = br; t.tgt = tgt;
        t.pc = pc; t.valid = v; t.mis = mis; t.cnt = cnt;
        return t;
    endfunction

    initial begin
        rst = 1'b1; fetch_ready_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0;
        m_phase = 0; m_pc = 0; m_cnt = 0; m_mis = 0;

        //              rst rdy br tgt            pc            v  mis cnt
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h4,        1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h8,        1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h8,        1, 0, 2));
        vecs.push_back(mk(0, 1, 1, 32'h100,      32'h100,      1, 0, 3));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h104,      1, 0, 4));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 4));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,        1, 0, 5));
        vecs.push_back(mk(0, 1, 1, 32'h102,      32'h0,        0, 1, 6));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 1, 6));
        vecs.push_back(mk(0, 1, 1, 32'h40,       32'h0,        0, 1, 6));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,        0, 1, 6));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h4,        1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 32'h200,      32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h300,      32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h300,      32'h300,      1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].ready, vecs[i].br, vecs[i].tgt);
            check($sformatf("vec%0d.pc", i),    pc_o,                   vecs[i].pc);
            check($sformatf("vec%0d.valid", i), {31'd0, pc_valid_o},    {31'd0, vecs[i].valid});
            check($sformatf("vec%0d.mis", i),   {31'd0, misalign_o},    {31'd0, vecs[i].mis});
            check($sformatf("vec%0d.cnt", i),   {28'd0, fetch_count_o}, 32'(vecs[i].cnt));
        end

        // Counter wrap: run 20 accepted fetches from a fresh reset.
        apply(1, 0, 0, 0);
        apply(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) apply(0, 1, 0, 0);
        check("wrap.cnt", {28'd0, fetch_count_o}, 32'd4);
        check("wrap.pc",  pc_o, 32'd80);

        // Random traffic against the model, starting from the current synced state.
        for (int i = 0; i < 600; i++) begin
            logic        r, rdy, br;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 49) == 0);
            rdy = $urandom_range(0, 1);
            br  = ($urandom_range(0, 5) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
            if (m_phase == 2 && $urandom_range(0, 9) == 0) r = 1'b1;
            apply(r, rdy, br, tgt);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
